// File: rtl/imem_loader.sv
// Loads a length-prefixed, big-endian byte stream into instruction memory while holding the CPU.
// Optional: define LOADER_CHECKSUM_EN to require a trailing 8-bit sum of all data bytes.
module imem_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam logic [16:0] Capacity = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StDone, StError
`ifdef LOADER_CHECKSUM_EN
    , StCsum
`endif
  } state_e;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e StTail = StCsum;
`else
  localparam state_e StTail = StDone;
`endif

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   words_q, words_d, words_inc;
  logic [16:0]       len_full;
  logic              ready, accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign len_full  = {1'b0, len_hi_q, in_data_i};
  assign words_inc = words_q + {{ADDR_W{1'b0}}, 1'b1};
  assign accept    = in_valid_i & ready;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      words_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      words_q  <= words_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    word_d   = word_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    words_d  = words_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d = StLenHi;
          words_d = '0;
          idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLenHi: begin
        if (accept) begin
          len_hi_d = in_data_i;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          if (len_full == '0) begin
            state_d = StTail;
          end else if (len_full > Capacity) begin
            state_d = StError;
          end else begin
            len_d   = len_full[ADDR_W:0];
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + in_data_i;
`endif
          if (idx_q == 2'd3) begin
            // Write fires next cycle; the stream keeps flowing underneath it.
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_W-1:0];
            wdata_d = {word_q, in_data_i};
            words_d = words_inc;
            if (words_inc == len_q) state_d = StTail;
          end else begin
            word_d = {word_q[15:0], in_data_i};
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) state_d = (in_data_i == csum_q) ? StDone : StError;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (state_q)
      StLenHi, StLenLo, StData: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StCsum: ready = 1'b1;
`endif
      default: ready = 1'b0;
    endcase
    in_ready_o     = ready;
    busy_o         = ready;
    cpu_hold_o     = (state_q != StDone);
    done_o         = (state_q == StDone);
    error_o        = (state_q == StError);
    imem_we_o      = we_q;
    imem_addr_o    = addr_q;
    imem_wdata_o   = wdata_q;
    words_loaded_o = words_q;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width of the instruction memory write port (capacity 2^ADDR_W words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; arms a new load.
REQ-005 in_valid  input  1  byte-stream source has a byte.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  loader accepts a byte; transfer = in_valid & in_ready on a rising edge.
REQ-008 imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of current write.
REQ-010 imem_wdata  output  32  word to write.
REQ-011 cpu_hold  output  1  holds the CPU's PC/fetch while high.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  load completed successfully (level).
REQ-014 error  output  1  load aborted (level).
REQ-015 words_loaded  output  ADDR_W+1  count of words written in current load.

Function
REQ-016 Stream format SHALL be: 16-bit word count N (high byte first), then 4N data bytes, each word big-endian (first byte -> imem_wdata[31:24]).
REQ-017 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, CSUM (macro only), DONE, ERROR.
REQ-018 IDLE/DONE/ERROR + start -> LEN_HI, clearing words_loaded, byte index, checksum, done, error; start in any other state SHALL be ignored.
REQ-019 in_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA, CSUM; 0 elsewhere.
REQ-020 LEN_LO accept: N==0 -> DONE; N>2^ADDR_W -> ERROR with no writes; else -> DATA.
REQ-021 In DATA, a 2-bit byte index SHALL advance per accepted byte and wrap 3->0; on the 4th byte, imem_we SHALL pulse high the following cycle with imem_addr = words_loaded (pre-increment, starting 0) and the assembled word; words_loaded increments in that same cycle.
REQ-022 in_ready SHALL stay high while imem_we pulses; back-to-back bytes every cycle SHALL be sustained with no loss.
REQ-023 After the write of word N, state SHALL be DONE (or CSUM with macro) in the cycle imem_we is high.
REQ-024 imem_we SHALL never assert outside DATA-completion pulses; imem_addr/imem_wdata hold last values between pulses.
REQ-025 busy = 1 in LEN_HI..CSUM; cpu_hold = 1 in all states except DONE; done = 1 only in DONE; error = 1 only in ERROR.
REQ-026 in_valid without in_ready SHALL have no effect; no timeout exists.

Reset
REQ-027 reset SHALL override all inputs, including a simultaneous start or accepted byte.
REQ-028 Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, busy 0, done 0, error 0, words_loaded 0.
REQ-029 reset mid-load SHALL abort with no further writes; words already written stay in memory.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: 8-bit checksum = sum mod 256 of all data bytes (not length bytes); after word N, state CSUM accepts one byte; match -> DONE, mismatch -> ERROR; N==0 still goes to CSUM with expected sum 0x00.
REQ-031 Macro undefined: no CSUM state or checksum register; word N -> DONE directly.

Verification
REQ-032 reset, start, stream 00 01 12 34 56 78 -> one imem_we pulse, addr 0, wdata 0x12345678, words_loaded 1, done 1, cpu_hold 0.
REQ-033 start, stream 00 41 (N=65, ADDR_W=6) -> ERROR, error 1, zero imem_we pulses, in_ready 0.
REQ-034 start, N=2, 8 bytes on consecutive cycles with in_valid held 1 -> two pulses, addr 0 then 1, no dropped byte, done 1 cycle after 8th byte.
REQ-035 LOADER_CHECKSUM_EN: N=1 bytes 01 02 03 04 then 0A -> done; repeat with 0B -> error, cpu_hold 1.
REQ-036 reset asserted after 2nd data byte of word 0 -> no imem_we, all outputs at reset values; new start loads correctly from addr 0.
REQ-037 start pulsed during DATA -> ignored, load completes normally; start in DONE -> cpu_hold 1, done 0 next cycle.
